// File: rtl/lsu_mem.sv
// Load/store unit: turns one pipeline memory instruction into a single bus
// transaction, aligns store data and extends load data for writeback.
module lsu_mem (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        flush_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_wdata_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        stall_req_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_wdata_o,
  output logic        misalign_o
);

  // Bus handshake: data_req_o rises in REQ and holds addr/be/wdata/we stable
  // until the cycle data_gnt_i=1; exactly one data_rvalid_i is then expected
  // in RESP. Grant outside REQ and rvalid outside RESP are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic        discard_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  rd_addr_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_d;

  assign access = (re_i | we_i) & ~flush_i;

  // Size 11 is reserved and behaves as a word, so size_i[1] alone means word.
  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      if (size_i == 2'b01)  misaligned = addr_i[0];
      else if (size_i[1])   misaligned = |addr_i[1:0];
    end
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (size_i)
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  // Lane select and extension of the returning load data.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0: byte_sel = data_rdata_i[7:0];
      2'd1: byte_sel = data_rdata_i[15:8];
      2'd2: byte_sel = data_rdata_i[23:16];
      default: byte_sel = data_rdata_i[31:24];
    endcase
    half_sel = lane_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    ext_d    = data_rdata_i;
    case (size_q)
      2'b00:   ext_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   ext_d = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ext_d = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rd_addr_q <= 5'd0;
      lane_q    <= 2'd0;
      rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (access && !misaligned) begin
            addr_q    <= {addr_i[31:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            we_q      <= we_i;
            size_q    <= size_i;
            uns_q     <= unsigned_i;
            rd_addr_q <= rd_addr_i;
            lane_q    <= addr_i[1:0];
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (flush_i)    discard_q <= 1'b1;
          if (data_gnt_i) state_q   <= RESP;
        end
        RESP: begin
          if (flush_i) discard_q <= 1'b1;
          if (data_rvalid_i) begin
            if (!we_q) rdata_q <= ext_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus outputs come only from state and captured registers.
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'h0;
    data_addr_o  = 32'h0;
    data_wdata_o = 32'h0;
    if (state_q == REQ) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be_q;
      data_addr_o  = addr_q;
      data_wdata_o = wdata_q;
    end
  end

  // Pipeline-facing outputs; the IDLE decisions are combinational on inputs,
  // so they are additionally masked while reset is held.
  always_comb begin
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    rd_we_o     = 1'b0;
    rd_addr_o   = rd_addr_i;
    rd_wdata_o  = rd_wdata_i;
    case (state_q)
      IDLE: begin
        if (!access) begin
          rd_we_o = rd_we_i;
        end else if (misaligned) begin
          misalign_o = 1'b1;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      REQ, RESP: stall_req_o = 1'b1;
      default: begin
        rd_we_o    = ~we_q & ~discard_q;
        rd_addr_o  = rd_addr_q;
        rd_wdata_o = rdata_q;
      end
    endcase
    if (!n_rst_i) begin
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      rd_we_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: each access runs cycle by cycle with the bus
// driven by hand and every output compared against hand-computed values.
module tb_lsu_mem;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        re_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        rd_we_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic [31:0] rd_wdata_i = 32'h0;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic        stall_req_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(flush_i),
    .re_i(re_i), .we_i(we_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i),
    .stall_req_o(stall_req_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
    .rd_wdata_o(rd_wdata_o), .misalign_o(misalign_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] state_now();
    return 32'(dut.state_q);
  endfunction

  // drivers
  task automatic clear_instr();
    re_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; flush_i = 1'b0;
    rd_we_i = 1'b0; rd_addr_i = 5'd0; rd_wdata_i = 32'h0;
  endtask

  // Called just after a falling edge with the DUT in IDLE; returns likewise.
  task automatic run_access(input string tag, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] rda, input int gnt_wait,
                            input logic flush_resp, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic exp_rd_we,
                            input logic [31:0] exp_rd_data);
    re_i = ~wr; we_i = wr; size_i = sz; unsigned_i = uns;
    addr_i = addr; wdata_i = wd; rd_addr_i = rda;
    #1;
    check_eq({tag, "_idle_stall"}, stall_req_o, 1'b1);
    check_eq({tag, "_idle_rdwe"}, rd_we_o, 1'b0);
    check_eq({tag, "_idle_req"}, data_req_o, 1'b0);
    @(negedge clk_i);
    clear_instr();
    for (int i = 0; i <= gnt_wait; i++) begin
      data_gnt_i = (i == gnt_wait);
      #1;
      check_eq({tag, "_req"}, data_req_o, 1'b1);
      check_eq({tag, "_we"}, data_we_o, wr);
      check_eq({tag, "_addr"}, data_addr_o, exp_addr);
      check_eq({tag, "_be"}, data_be_o, exp_be);
      check_eq({tag, "_wdata"}, data_wdata_o, exp_wdata);
      check_eq({tag, "_req_stall"}, stall_req_o, 1'b1);
      @(negedge clk_i);
    end
    data_gnt_i = 1'b0;
    if (flush_resp) begin
      flush_i = 1'b1;
      #1;
      check_eq({tag, "_flush_state"}, state_now(), 32'd2);
      @(negedge clk_i);
      flush_i = 1'b0;
    end
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    #1;
    check_eq({tag, "_resp_req"}, data_req_o, 1'b0);
    check_eq({tag, "_resp_stall"}, stall_req_o, 1'b1);
    @(negedge clk_i);
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    #1;
    check_eq({tag, "_done_state"}, state_now(), 32'd3);
    check_eq({tag, "_done_stall"}, stall_req_o, 1'b0);
    check_eq({tag, "_done_rdwe"}, rd_we_o, exp_rd_we);
    if (exp_rd_we) begin
      check_eq({tag, "_done_rdaddr"}, rd_addr_o, rda);
      check_eq({tag, "_done_rddata"}, rd_wdata_o, exp_rd_data);
    end
    @(negedge clk_i);
    #1;
    check_eq({tag, "_back_idle"}, state_now(), 32'd0);
  endtask

  int stall_cnt;
  int req_cnt;

  initial begin
    clear_instr();
    #1;
    check_eq("rst_state", state_now(), 32'd0);
    check_eq("rst_req", data_req_o, 1'b0);
    check_eq("rst_stall", stall_req_o, 1'b0);
    check_eq("rst_rdwe", rd_we_o, 1'b0);
    check_eq("rst_misalign", misalign_o, 1'b0);
    repeat (2) @(negedge clk_i);
    n_rst_i = 1'b1;
    @(negedge clk_i);

    // GPR pass-through for a non-memory op
    rd_we_i = 1'b1; rd_addr_i = 5'd5; rd_wdata_i = 32'hA5;
    #1;
    check_eq("pass_we", rd_we_o, 1'b1);
    check_eq("pass_addr", rd_addr_o, 32'd5);
    check_eq("pass_data", rd_wdata_o, 32'hA5);
    check_eq("pass_stall", stall_req_o, 1'b0);
    @(negedge clk_i);
    clear_instr();

    //        tag    wr  sz     uns  addr          wdata         rd  gw fl rdata          exp_addr      be       exp_wdata     rdwe exp_rd
    run_access("lb",  0, 2'b00, 0, 32'h0000_1003, 32'h0,        7, 2, 0, 32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0,        1, 32'hFFFF_FF80);
    run_access("lbu", 0, 2'b00, 1, 32'h0000_5001, 32'h0,        3, 0, 0, 32'h0000_AB00, 32'h0000_5000, 4'b0010, 32'h0,        1, 32'h0000_00AB);
    run_access("lh",  0, 2'b01, 0, 32'h0000_6002, 32'h0,        4, 1, 0, 32'h8001_0000, 32'h0000_6000, 4'b1100, 32'h0,        1, 32'hFFFF_8001);
    run_access("lhu", 0, 2'b01, 1, 32'h0000_6000, 32'h0,        8, 0, 0, 32'h1234_F00D, 32'h0000_6000, 4'b0011, 32'h0,        1, 32'h0000_F00D);
    run_access("lw3", 0, 2'b11, 0, 32'h0000_6004, 32'h0,       31, 0, 0, 32'hDEAD_BEEF, 32'h0000_6004, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF);
    run_access("sw",  1, 2'b10, 0, 32'h0000_8000, 32'hCAFEF00D, 2, 1, 0, 32'h1111_1111, 32'h0000_8000, 4'b1111, 32'hCAFEF00D, 0, 32'h0);
    run_access("sb",  1, 2'b00, 0, 32'h0000_9001, 32'hFFFFFF12, 2, 0, 0, 32'h0,        32'h0000_9000, 4'b0010, 32'h1212_1212, 0, 32'h0);
    run_access("lwf", 0, 2'b10, 0, 32'h0000_4000, 32'h0,        6, 0, 1, 32'h1234_5678, 32'h0000_4000, 4'b1111, 32'h0,        0, 32'h0);
    run_access("aftf",0, 2'b00, 1, 32'h0000_5001, 32'h0,        3, 0, 0, 32'h0000_AB00, 32'h0000_5000, 4'b0010, 32'h0,        1, 32'h0000_00AB);

    // SH with gnt and rvalid held high throughout: stray ones are ignored
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    we_i = 1'b1; size_i = 2'b01; addr_i = 32'h0000_2002; wdata_i = 32'h0000_BEEF;
    stall_cnt = 0; req_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (stall_req_o) stall_cnt++;
      if (data_req_o) begin
        req_cnt++;
        check_eq("sh_be", data_be_o, 4'b1100);
        check_eq("sh_wdata", data_wdata_o, 32'hBEEF_BEEF);
        check_eq("sh_addr", data_addr_o, 32'h0000_2000);
      end
      if (c == 3) check_eq("sh_done_rdwe", rd_we_o, 1'b0);
      @(negedge clk_i);
      clear_instr();
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    check_eq("sh_stall_cycles", stall_cnt, 32'd3);
    check_eq("sh_req_cycles", req_cnt, 32'd1);

    // misaligned word load, then misaligned half store
    re_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_3001; rd_we_i = 1'b1;
    #1;
    check_eq("mis_lw_flag", misalign_o, 1'b1);
    check_eq("mis_lw_stall", stall_req_o, 1'b0);
    check_eq("mis_lw_req", data_req_o, 1'b0);
    check_eq("mis_lw_rdwe", rd_we_o, 1'b0);
    @(negedge clk_i);
    clear_instr();
    #1;
    check_eq("mis_lw_state", state_now(), 32'd0);
    check_eq("mis_lw_clear", misalign_o, 1'b0);
    check_eq("mis_lw_req2", data_req_o, 1'b0);
    we_i = 1'b1; size_i = 2'b01; addr_i = 32'h0000_2001;
    #1;
    check_eq("mis_sh_flag", misalign_o, 1'b1);
    @(negedge clk_i);
    clear_instr();
    #1;
    check_eq("mis_sh_state", state_now(), 32'd0);

    // flushed instruction in IDLE is not an access
    re_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_3001; flush_i = 1'b1;
    #1;
    check_eq("flush_idle_mis", misalign_o, 1'b0);
    check_eq("flush_idle_stall", stall_req_o, 1'b0);
    @(negedge clk_i);
    clear_instr();

    // reset asserted while in REQ, stray rvalid afterwards
    re_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_7000; rd_addr_i = 5'd9;
    @(negedge clk_i);
    clear_instr();
    #1;
    check_eq("rstreq_req", data_req_o, 1'b1);
    #1;
    n_rst_i = 1'b0;
    #1;
    check_eq("rstreq_req_low", data_req_o, 1'b0);
    check_eq("rstreq_state", state_now(), 32'd0);
    check_eq("rstreq_stall", stall_req_o, 1'b0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("rstreq_rdwe", rd_we_o, 1'b0);
      check_eq("rstreq_idle", state_now(), 32'd0);
      check_eq("rstreq_noreq", data_req_o, 1'b0);
      @(negedge clk_i);
    end
    data_rvalid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
